// File: rtl/ov7670_config_sequencer.sv
// OV7670 register-table sequencer: presents one {rega,value} pair at a time to the
// SCCB write engine, inserting power-up and delay waits, and raises done at the end marker.
module ov7670_config_sequencer #(
    parameter int POWERUP_CYCLES = 1_000_000,
    parameter int DELAY_CYCLES   = 500_000,
    parameter int IDX_W          = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             taken,
    input  logic             restart,
    output logic             send,
    output logic [7:0]       rega,
    output logic [7:0]       value,
    output logic             done,
    output logic [IDX_W-1:0] index
);

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_FETCH,
        ST_DECODE,
        ST_SEND,
        ST_DELAY,
        ST_DONE
    } state_t;

    localparam logic [15:0] END_MARK   = 16'hFFFF;
    localparam logic [15:0] DELAY_MARK = 16'hFFF0;
    // Parameters of 0 or 1 collapse to a single-cycle wait.
    localparam logic [20:0] PU_LAST = (POWERUP_CYCLES > 1) ? 21'(POWERUP_CYCLES - 1) : 21'd0;
    localparam logic [20:0] DL_LAST = (DELAY_CYCLES > 1) ? 21'(DELAY_CYCLES - 1) : 21'd0;

    logic [1:0]       rst_sync_q;
    logic             rst_n_int;
    state_t           state_q;
    logic [20:0]      cnt_q;
    logic             send_q;
    logic             done_q;
    logic [7:0]       rega_q;
    logic [7:0]       value_q;
    logic [IDX_W-1:0] index_q;
    logic [15:0]      rom_data;

    // Assertion is immediate; release is retimed through two flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    always_comb begin
        rom_data = END_MARK;
        case (index_q)
            IDX_W'(0):  rom_data = 16'h1280;
            IDX_W'(1):  rom_data = DELAY_MARK;
            IDX_W'(2):  rom_data = 16'h1204;
            IDX_W'(3):  rom_data = 16'h1180;
            IDX_W'(4):  rom_data = 16'h0C04;
            IDX_W'(5):  rom_data = 16'h3E19;
            IDX_W'(6):  rom_data = 16'h40D0;
            IDX_W'(7):  rom_data = 16'h8C00;
            IDX_W'(8):  rom_data = 16'h703A;
            IDX_W'(9):  rom_data = 16'h7135;
            IDX_W'(10): rom_data = 16'h7211;
            IDX_W'(11): rom_data = 16'h73F1;
            IDX_W'(12): rom_data = 16'hA202;
            default:    rom_data = END_MARK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q <= ST_POWERUP;
            cnt_q   <= '0;
            send_q  <= 1'b0;
            done_q  <= 1'b0;
            rega_q  <= '0;
            value_q <= '0;
            index_q <= '0;
        end else begin
            case (state_q)
                ST_POWERUP: begin
                    if (cnt_q == PU_LAST) state_q <= ST_FETCH;
                    else                  cnt_q   <= cnt_q + 21'd1;
                end
                ST_FETCH: begin
                    {rega_q, value_q} <= rom_data;
                    state_q           <= ST_DECODE;
                end
                ST_DECODE: begin
                    if ({rega_q, value_q} == END_MARK) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if ({rega_q, value_q} == DELAY_MARK) begin
                        cnt_q   <= '0;
                        state_q <= ST_DELAY;
                    end else begin
                        send_q  <= 1'b1;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (taken) begin
                        send_q  <= 1'b0;
                        index_q <= index_q + IDX_W'(1);
                        state_q <= ST_FETCH;
                    end
                end
                ST_DELAY: begin
                    if (cnt_q == DL_LAST) begin
                        index_q <= index_q + IDX_W'(1);
                        state_q <= ST_FETCH;
                    end else begin
                        cnt_q <= cnt_q + 21'd1;
                    end
                end
                ST_DONE: begin
                    if (restart) begin
                        done_q  <= 1'b0;
                        index_q <= '0;
                        state_q <= ST_FETCH;
                    end
                end
                default: state_q <= ST_POWERUP;
            endcase
        end
    end

    assign send  = send_q;
    assign done  = done_q;
    assign rega  = rega_q;
    assign value = value_q;
    assign index = index_q;

endmodule

// File: doc/ov7670_config_sequencer.md
Name: ov7670_config_sequencer

Overview:
- Upstream feeder of the SCCB write engine: walks an internal register/value table for the OV7670 and presents one pair at a time on rega/value with send.
- Advances on the engine's one-cycle taken pulse.
- Inserts timed waits (power-up, post-soft-reset) and asserts done after the end marker, which gates the capture pipeline.

Parameters:
- POWERUP_CYCLES, 1_000_000, clk cycles idle after reset release before the first entry (20 ms at 50 MHz).
- DELAY_CYCLES, 500_000, clk cycles waited on a delay entry (10 ms at 50 MHz).
- IDX_W, 8, table index width; table holds up to 2**IDX_W entries.

Ports:
- clk  in  1  50 MHz system clock.
- reset_n  in  1  asynchronous active-low reset.
- taken  in  1  one-cycle pulse from SCCB engine: current rega/value accepted.
- restart  in  1  one-cycle request to rerun the table; honoured only in DONE.
- send  out  1  rega/value valid; request to SCCB engine.
- rega  out  8  register address of current entry.
- value  out  8  data of current entry.
- done  out  1  table complete, sensor configured.
- index  out  IDX_W  current table index (debug).

Behaviour:
- Reset (async, reset_n=0): send=0, rega=8'h00, value=8'h00, done=0, index=0, state=POWERUP, counter=0. Deassertion is released synchronously internally (2-flop).
- Table (synchronous ROM, 1-cycle read latency), entry {rega,value}:
  - 0: 12/80 (COM7 soft reset).
  - 1: FF/F0 (delay).
  - 2: 12/04 (RGB).
  - 3: 11/80 (CLKRC).
  - Following entries: team QVGA RGB565 set, terminated by FF/FF.
  - Any index past the last defined entry reads FF/FF.
- Entry classes: FF/FF = end marker; FF/F0 = delay marker; all others = write.
- States:
  - POWERUP: count to POWERUP_CYCLES-1, then FETCH.
  - FETCH: ROM addressed by index; at cycle end rega/value load the entry; next state DECODE. send=0.
  - DECODE: end marker -> DONE. Delay marker -> DELAY with counter cleared. Otherwise -> SEND with send=1 registered, so send rises 2 cycles after entering FETCH.
  - SEND: send=1, rega/value held stable. On taken: send<=0, index<=index+1, -> FETCH. Without taken, stay indefinitely (no timeout).
  - DELAY: send=0; count to DELAY_CYCLES-1, then index<=index+1, -> FETCH.
  - DONE: done=1, send=0, rega/value hold the marker. restart=1: done<=0, index<=0, -> FETCH (no power-up wait).
- taken outside SEND is ignored; index never changes on a stray taken.
- restart outside DONE is ignored (prevents aborting an in-flight SCCB frame).
- taken and restart in the same cycle: only one can be honoured by state, so no conflict.
- Index is IDX_W wide and never wraps: the out-of-range FF/FF forces DONE before overflow.
- Counters are 21 bits wide, sized for the parameter defaults. Parameters of 0 or 1 give a 1-cycle wait.
- Reset mid-operation: immediate return to reset values. Any SCCB frame in flight is the engine's concern; the sequencer restarts from POWERUP and index 0.
- Throughput: one write per SCCB frame. Sequencer overhead is 2 cycles per entry, well inside the engine's idle gap.

Test Plan:
- Power-up: POWERUP_CYCLES=10, DELAY_CYCLES=20, release reset at t0 -> send=0 for 10 cycles plus FETCH/DECODE; send rises with rega=8'h12, value=8'h80, index=0.
- Handshake hold: withhold taken 1000 cycles -> send stays 1 and rega/value constant. Pulse taken -> send=0 next cycle, index=1.
- Delay entry: after entry 0 taken -> send stays 0 for 20 counted cycles plus overhead; next presented pair 12/04 with index=2; no send during delay.
- Full run with auto-ack model (taken 5 cycles after each send) -> one taken per write entry, delay entries never presented with send=1, done=1 after FF/FF, send=0 thereafter.
- Stray/illegal inputs: taken pulses during DELAY and DONE, restart pulse during SEND -> index, state, and outputs unchanged. Restart in DONE -> done=0 next cycle, pair 12/80 re-presented, no power-up wait.
- Async reset mid-SEND at index 3: reset_n low between clock edges -> send, done, index, rega, value read 0 without a clock edge; sequence reruns from POWERUP after release.
